// File: rtl/os_inst_sequencer.sv
// Instruction sequencer for one output-stationary layer: loads activations and
// weights per input-channel pass, executes, then recalls and drains the psums.
module os_inst_sequencer #(
  parameter int n_ic    = 8,
  parameter int len_kij = 9,
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int w_base  = 576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [63:0] inst,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L0_LD  = 3'd1,
    S_L1_LD  = 3'd2,
    S_PRIME  = 3'd3,
    S_EXEC   = 3'd4,
    S_RECALL = 3'd5,
    S_DRAIN  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [63:0] IDLE_WORD = 64'h0000_0011_800C_0000;
  localparam logic [10:0] KIJ       = 11'(len_kij);
  localparam logic [10:0] WB        = 11'(w_base);
  localparam logic [10:0] LD_LAST   = 11'(len_kij);
  localparam logic [10:0] EX_LAST   = 11'(len_kij + col + row - 1);
  localparam logic [10:0] IC_LAST   = 11'(n_ic - 1);
  localparam logic [10:0] D_LAST    = 11'(col - 1);

  state_t      state_q, state_d;
  logic [10:0] ic_q, ic_d;
  logic [10:0] cnt_q, cnt_d;
  logic        xfer_q, xfer_d;
  logic [63:0] inst_q, inst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Instruction word for a given state/counter; untouched fields keep IDLE values.
  function automatic logic [63:0] encode(input state_t st, input logic [10:0] ic,
                                         input logic [10:0] cnt, input logic xf);
    logic [63:0] w;
    logic [10:0] base;
    w    = IDLE_WORD;
    base = ic * KIJ;
    case (st)
      S_L0_LD: begin
        w[17:7] = base + cnt;
        w[19]   = (cnt == LD_LAST);
        w[2]    = (cnt != 11'd0);
      end
      S_L1_LD: begin
        w[17:7] = WB + base + cnt;
        w[19]   = (cnt == LD_LAST);
        w[37]   = (cnt != 11'd0);
      end
      S_PRIME: w[3] = 1'b1;
      S_EXEC: begin
        w[3] = (cnt < KIJ);
        w[1] = (cnt < KIJ);
      end
      S_RECALL: begin
        w[38] = 1'b1;
        w[34] = 1'b1;
      end
      S_DRAIN: begin
        w[39]    = 1'b1;
        w[34]    = 1'b1;
        w[30:20] = D_LAST - cnt;
        w[6]     = xf;
        w[32]    = ~xf;
        w[31]    = ~xf;
      end
      default: w = IDLE_WORD;
    endcase
    return w;
  endfunction

  // Next-state and counter logic; a DRAIN cycle is a transfer when xfer_q is set,
  // which holds ofifo_valid as sampled on the edge that produced that cycle's word.
  always_comb begin
    state_d = state_q;
    ic_d    = ic_q;
    cnt_d   = cnt_q;
    xfer_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_L0_LD;
          ic_d    = 11'd0;
          cnt_d   = 11'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_L0_LD: begin
        if (cnt_q == LD_LAST) begin
          state_d = S_L1_LD;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_L1_LD: begin
        if (cnt_q == LD_LAST) begin
          state_d = S_PRIME;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_PRIME: begin
        state_d = S_EXEC;
        cnt_d   = 11'd0;
      end
      S_EXEC: begin
        if (cnt_q == EX_LAST) begin
          cnt_d = 11'd0;
          if (ic_q < IC_LAST) begin
            ic_d    = ic_q + 11'd1;
            state_d = S_L0_LD;
          end else begin
            state_d = S_RECALL;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_RECALL: begin
        state_d = S_DRAIN;
        cnt_d   = 11'd0;
        xfer_d  = ofifo_valid;
      end
      S_DRAIN: begin
        xfer_d = ofifo_valid;
        if (xfer_q) begin
          if (cnt_q == D_LAST) begin
            state_d = S_DONE;
            cnt_d   = 11'd0;
            xfer_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ic_d    = 11'd0;
        cnt_d   = 11'd0;
      end
      default: begin
        state_d = S_IDLE;
        ic_d    = 11'd0;
        cnt_d   = 11'd0;
      end
    endcase
  end

  // Output words are computed from the next state so they register alongside it.
  always_comb begin
    inst_d = encode(state_d, ic_d, cnt_d, xfer_d);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ic_q    <= 11'd0;
      cnt_q   <= 11'd0;
      xfer_q  <= 1'b0;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
